// File: rtl/ikbd_mouse_mux.sv
// ikbd_mouse_mux: shares the IKBD joystick-0 port between a relative mouse
// (replayed as paced quadrature from saturating delta accumulators) and a
// digital joystick. Any joystick activity takes the port; a meaningful mouse
// report with the joystick idle hands it back.
module ikbd_mouse_mux #(
  parameter int STEP_DIV = 200,
  parameter int ACC_MAX  = 511
) (
  input  logic       clk,
  input  logic       res_n,
  input  logic       mouse_strobe,
  input  logic [7:0] mouse_dx,
  input  logic [7:0] mouse_dy,
  input  logic [1:0] mouse_btn,
  input  logic [5:0] joy_in,
  output logic [5:0] joystick0,
  output logic       joy_mode
);

  typedef enum logic {
    MODE_MOUSE = 1'b0,
    MODE_JOY   = 1'b1
  } mode_t;

  localparam logic [15:0]        TICK_LAST = 16'(STEP_DIV - 1);
  localparam logic signed [11:0] ACC_LIM   = 12'(ACC_MAX);

  mode_t              state, state_next;
  logic [15:0]        tick_cnt;
  logic               tick;
  logic signed [9:0]  acc_x, acc_y, acc_x_next, acc_y_next;
  logic [1:0]         q_x, q_y, q_x_next, q_y_next;
  logic [1:0]         btn, btn_next;
  logic [5:0]         port_next;
  logic signed [11:0] step_x, step_y;
  logic signed [11:0] dx_ext, dy_ext, acc_x_ext, acc_y_ext;

  // Clamp a widened accumulator sum back into the symmetric +/-ACC_MAX range.
  function automatic logic signed [9:0] sat_acc(input logic signed [11:0] v);
    logic signed [11:0] r;
    if (v > ACC_LIM)
      r = ACC_LIM;
    else if (v < -ACC_LIM)
      r = -ACC_LIM;
    else
      r = v;
    return r[9:0];
  endfunction

  // Advance a 2-bit Gray phase one position in the direction of s.
  function automatic logic [1:0] gray_step(input logic [1:0] q,
                                           input logic signed [11:0] s);
    if (s > 0)
      return {q[0], ~q[1]};
    else if (s < 0)
      return {~q[0], q[1]};
    else
      return q;
  endfunction

  // Mouse-mode port image: {right, left, YB, YA, XA, XB}.
  function automatic logic [5:0] mouse_port(input logic [1:0] qx,
                                            input logic [1:0] qy,
                                            input logic [1:0] b);
    return {b, qy[0], qy[1], qx[1], qx[0]};
  endfunction

  assign tick      = (tick_cnt == TICK_LAST);
  assign joy_mode  = (state == MODE_JOY);
  assign dx_ext    = {{4{mouse_dx[7]}}, mouse_dx};
  assign dy_ext    = {{4{mouse_dy[7]}}, mouse_dy};
  assign acc_x_ext = {{2{acc_x[9]}}, acc_x};
  assign acc_y_ext = {{2{acc_y[9]}}, acc_y};

  // Free-running step pacer; wraps to zero on the tick cycle.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n)
      tick_cnt <= '0;
    else if (tick)
      tick_cnt <= '0;
    else
      tick_cnt <= tick_cnt + 16'd1;
  end

  // Unit of motion each axis consumes on this cycle's tick (toward zero).
  always_comb begin
    step_x = '0;
    step_y = '0;
    if (tick && acc_x > 0)
      step_x = 12'sd1;
    else if (tick && acc_x < 0)
      step_x = -12'sd1;
    if (tick && acc_y > 0)
      step_y = 12'sd1;
    else if (tick && acc_y < 0)
      step_y = -12'sd1;
  end

  // Arbitration, accumulator/phase update and next port image.
  always_comb begin
    state_next = state;
    acc_x_next = acc_x;
    acc_y_next = acc_y;
    q_x_next   = q_x;
    q_y_next   = q_y;
    btn_next   = btn;
    port_next  = mouse_port(q_x, q_y, btn);
    case (state)
      MODE_MOUSE: begin
        if (joy_in != 6'd0) begin
          state_next = MODE_JOY;
          acc_x_next = '0;
          acc_y_next = '0;
          btn_next   = 2'b00;
          port_next  = joy_in;
        end else begin
          q_x_next   = gray_step(q_x, step_x);
          q_y_next   = gray_step(q_y, step_y);
          acc_x_next = sat_acc(acc_x_ext - step_x);
          acc_y_next = sat_acc(acc_y_ext - step_y);
          if (mouse_strobe) begin
            acc_x_next = sat_acc(acc_x_ext + dx_ext - step_x);
            acc_y_next = sat_acc(acc_y_ext + dy_ext - step_y);
            btn_next   = mouse_btn;
          end
          port_next = mouse_port(q_x_next, q_y_next, btn_next);
        end
      end
      MODE_JOY: begin
        port_next = joy_in;
        if (joy_in == 6'd0 && mouse_strobe &&
            (mouse_dx != 8'd0 || mouse_dy != 8'd0 || mouse_btn != btn)) begin
          state_next = MODE_MOUSE;
          acc_x_next = sat_acc(dx_ext);
          acc_y_next = sat_acc(dy_ext);
          btn_next   = mouse_btn;
          port_next  = mouse_port(q_x, q_y, mouse_btn);
        end
      end
      default: state_next = MODE_MOUSE;
    endcase
  end

  // State, accumulators, phases, buttons and the registered port.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state     <= MODE_MOUSE;
      acc_x     <= '0;
      acc_y     <= '0;
      q_x       <= 2'b00;
      q_y       <= 2'b00;
      btn       <= 2'b00;
      joystick0 <= 6'b000000;
    end else begin
      state     <= state_next;
      acc_x     <= acc_x_next;
      acc_y     <= acc_y_next;
      q_x       <= q_x_next;
      q_y       <= q_y_next;
      btn       <= btn_next;
      joystick0 <= port_next;
    end
  end

endmodule
